// File: rtl/acc_dispatch_sched.sv
// acc_dispatch_sched: instruction queue and dispatch sequencer for the
// FFT/FIR/IIR accelerators. Opcodes are buffered in a small FIFO and issued
// one at a time. Each issue raises one accelerator enable, waits for that
// accelerator's read_done and write_done, then pulses acc_done. Before the
// next entry starts, it waits for both done flags to drop.
//
// Ports:
//   clk, reset (async, active-low)
//   instr_valid/instr/instr_ready : instruction push handshake (opcode = instr[1:0])
//   {fft,fir,iir}_{read,write}_done : accelerator completion flags
//   {fft,fir,iir}_enable : registered, at most one high
//   acc_done/done_op : registered one-cycle completion pulse and its opcode
//   busy, fifo_count : status from registered state
//   timeout_err : registered watchdog pulse (only with ACC_TIMEOUT_EN)
//
// Optional feature macro: ACC_TIMEOUT_EN adds the RUN watchdog.
module acc_dispatch_sched #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned CNT_W          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             fft_read_done,
  input  logic             fft_write_done,
  input  logic             fir_read_done,
  input  logic             fir_write_done,
  input  logic             iir_read_done,
  input  logic             iir_write_done,
  output logic             fft_enable,
  output logic             fir_enable,
  output logic             iir_enable,
  output logic             acc_done,
  output logic [1:0]       done_op,
  output logic             busy,
`ifdef ACC_TIMEOUT_EN
  output logic             timeout_err,
`endif
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE, DRAIN} state_t;

  state_t           state_q, state_nx;
  logic [1:0]       op_q, op_nx;
  logic             rd_seen_q, rd_nx;
  logic             wr_seen_q, wr_nx;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       mem_q [DEPTH];
  logic             push, pop, full;
  logic             sel_rd, sel_wr;
  logic             tmo_hit, err_nx;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^instr[31:2];

  // FIFO status; NOP opcodes complete the handshake but are never stored
  assign full        = (count_q == CNT_W'(DEPTH));
  assign instr_ready = reset && !full;
  assign push        = instr_valid && instr_ready && (instr[1:0] != 2'b00);
  assign fifo_count  = count_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);

  // Done flags of the accelerator selected by the latched opcode
  always_comb begin
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    case (op_q)
      2'b01:   begin sel_rd = fft_read_done; sel_wr = fft_write_done; end
      2'b10:   begin sel_rd = fir_read_done; sel_wr = fir_write_done; end
      2'b11:   begin sel_rd = iir_read_done; sel_wr = iir_write_done; end
      default: begin sel_rd = 1'b0;          sel_wr = 1'b0;           end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    op_nx    = op_q;
    rd_nx    = rd_seen_q;
    wr_nx    = wr_seen_q;
    pop      = 1'b0;
    err_nx   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          op_nx    = mem_q[rd_ptr_q];
          rd_nx    = 1'b0;
          wr_nx    = 1'b0;
          state_nx = RUN;
        end
      end
      RUN: begin
        // Current-cycle flags count, so simultaneous dones finish at once
        rd_nx = rd_seen_q | sel_rd;
        wr_nx = wr_seen_q | sel_wr;
        if (rd_nx && wr_nx) begin
          state_nx = DONE;
        end else if (tmo_hit) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      end
      DONE: state_nx = DRAIN;
      // Wait for stale dones to clear so they cannot finish the next op
      DRAIN: begin
        if (!sel_rd && !sel_wr) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FIFO storage; flushed by pointer reset only
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instr[1:0];
  end

  // State, pointers and registered outputs (derived from next state)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      rd_seen_q  <= 1'b0;
      wr_seen_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fft_enable <= 1'b0;
      fir_enable <= 1'b0;
      iir_enable <= 1'b0;
      acc_done   <= 1'b0;
      done_op    <= 2'b00;
    end else begin
      state_q   <= state_nx;
      op_q      <= op_nx;
      rd_seen_q <= rd_nx;
      wr_seen_q <= wr_nx;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      fft_enable <= (state_nx == RUN) && (op_nx == 2'b01);
      fir_enable <= (state_nx == RUN) && (op_nx == 2'b10);
      iir_enable <= (state_nx == RUN) && (op_nx == 2'b11);
      acc_done   <= (state_nx == DONE);
      done_op    <= (state_nx == DONE) ? op_q : 2'b00;
    end
  end

`ifdef ACC_TIMEOUT_EN
  logic [TCW-1:0] tcnt_q;

  assign tmo_hit = (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));

  // RUN-cycle watchdog; held at zero outside RUN so entry starts from 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q      <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt_q      <= (state_q == RUN) ? tcnt_q + TCW'(1) : '0;
      timeout_err <= err_nx;
    end
  end
`else
  logic [32:0] unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign unused_timeout_cfg = {err_nx, 32'(TIMEOUT_CYCLES)};
`endif

endmodule
